// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one sync instruction memory between fetch (F, read-only)
// and debug/loader (D, read/write) with fetch priority and D anti-starvation.
// Ports: clk, reset (async, active-high)
//   F: f_req, f_addr -> f_gnt, f_rvalid, f_rdata, f_err
//   D: d_req, d_we, d_addr, d_wdata -> d_gnt, d_rvalid, d_rdata, d_err
//   M: mem_en, mem_we, mem_addr, mem_wdata -> mem_rdata (1-cycle latency)
module imem_arbiter #(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned MAX_WAIT = 4,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     f_req,
  input  logic [31:0]              f_addr,
  output logic                     f_gnt,
  output logic                     f_rvalid,
  output logic [31:0]              f_rdata,
  output logic                     f_err,
  input  logic                     d_req,
  input  logic                     d_we,
  input  logic [31:0]              d_addr,
  input  logic [31:0]              d_wdata,
  output logic                     d_gnt,
  output logic                     d_rvalid,
  output logic [31:0]              d_rdata,
  output logic                     d_err,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [$clog2(DEPTH)-1:0] mem_addr,
  output logic [31:0]              mem_wdata,
  input  logic [31:0]              mem_rdata
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned WW = $clog2(MAX_WAIT + 1) + 1;
  localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);
  localparam logic [29:0] DEPTH_W = 30'(DEPTH);

  typedef enum logic [1:0] {
    R_NONE,
    R_F,
    R_D
  } owner_e;

  owner_e        owner_q, owner_d;
  logic          err_q, err_d;
  logic          we_q, we_d;
  logic [WW-1:0] wait_q, wait_d;

  logic          win_f, win_d;
  logic          f_legal, d_legal;
  logic [31:0]   resp_data;

  function automatic logic legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a[31:2] < DEPTH_W);
  endfunction

  assign f_legal = legal(f_addr);
  assign d_legal = legal(d_addr);

  // D wins when F is idle or D has waited its full budget.
  // Grants are masked while reset is high.
  assign win_d = ~reset & d_req
               & (~f_req | (wait_q == WMAX));
  assign win_f = ~reset & f_req & ~win_d;
  assign f_gnt = win_f;
  assign d_gnt = win_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q <= R_NONE;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      wait_q  <= '0;
    end else begin
      owner_q <= owner_d;
      err_q   <= err_d;
      we_q    <= we_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    owner_d   = R_NONE;
    err_d     = 1'b0;
    we_d      = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (1'b1)
      win_d: begin
        owner_d   = R_D;
        err_d     = ~d_legal;
        we_d      = d_we;
        mem_en    = d_legal;
        mem_we    = d_legal & d_we;
        mem_addr  = d_addr[2 +: AW];
        mem_wdata = d_wdata;
      end
      win_f: begin
        owner_d  = R_F;
        err_d    = ~f_legal;
        mem_en   = f_legal;
        mem_addr = f_addr[2 +: AW];
      end
      default: ;
    endcase
  end

  // Consecutive-denial counter, saturating at MAX_WAIT.
  always_comb begin
    wait_d = wait_q;
    if (win_d || !d_req) begin
      wait_d = '0;
    end else if (wait_q != WMAX) begin
      wait_d = wait_q + 1'b1;
    end
  end

  // Writes ack with zero; errors return a NOP.
  always_comb begin
    resp_data = mem_rdata;
    if (err_q) begin
      resp_data = NOP_INSN;
    end else if (we_q) begin
      resp_data = '0;
    end
  end

  assign f_rvalid = (owner_q == R_F);
  assign d_rvalid = (owner_q == R_D);
  assign f_err    = f_rvalid & err_q;
  assign d_err    = d_rvalid & err_q;
  assign f_rdata  = f_rvalid ? resp_data : NOP_INSN;
  assign d_rdata  = d_rvalid ? resp_data : NOP_INSN;

endmodule
